// File: rtl/wbs_multibank_ctrl.sv
// wbs_multibank_ctrl: Wishbone slave exposing mode/debug/status registers and NUM_BANKS
// single-port SRAM banks whose entries are wider than one bus word. Partial entries are
// collected in a shadow register so each entry is committed with one SRAM write.
module wbs_multibank_ctrl #(
  parameter int unsigned NUM_BANKS    = 4,
  parameter int unsigned MEM_W        = 64,
  parameter int unsigned MEM_ADDR_W   = 9,
  parameter int unsigned READ_LATENCY = 1
) (
  input  logic                       wb_clk_i,
  input  logic                       wb_rst_i,
  input  logic                       wbs_stb_i,
  input  logic                       wbs_cyc_i,
  input  logic                       wbs_we_i,
  input  logic [3:0]                 wbs_sel_i,
  input  logic [31:0]                wbs_dat_i,
  input  logic [31:0]                wbs_adr_i,
  output logic                       wbs_ack_o,
  output logic [31:0]                wbs_dat_o,
  output logic                       wbs_mode,
  output logic                       wbs_debug,
  output logic [NUM_BANKS-1:0]       mem_csb,
  output logic [NUM_BANKS-1:0]       mem_web,
  output logic [MEM_ADDR_W-1:0]      mem_addr,
  output logic [MEM_W-1:0]           mem_wdata,
  input  logic [NUM_BANKS*MEM_W-1:0] mem_rdata
);

  localparam int unsigned WPE    = (MEM_W + 31) / 32;
  localparam int unsigned WSEL_W = $clog2(WPE);
  localparam int unsigned SH_W   = WPE * 32;
  localparam int unsigned BANK_W = 4;
  localparam int unsigned TAG_W  = BANK_W + MEM_ADDR_W;
  localparam int unsigned CNT_W  = 3;

  typedef enum logic [2:0] {IDLE, RD_REQ, RD_WAIT, WR, ACK} state_t;

  state_t state_q, state_d;

  logic [MEM_W-1:0]      sh_data_q, sh_data_d;
  logic [TAG_W-1:0]      sh_tag_q, sh_tag_d;
  logic                  sh_valid_q, sh_valid_d;
  logic [BANK_W-1:0]     req_bank_q, req_bank_d;
  logic [WSEL_W-1:0]     req_word_q, req_word_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic                  drop_q, drop_d;

  logic                  ack_d, mode_d, debug_d;
  logic [31:0]           dat_d;
  logic [NUM_BANKS-1:0]  csb_d, web_d;
  logic [MEM_ADDR_W-1:0] addr_d;
  logic [MEM_W-1:0]      wdata_d;

  logic                  bus_req, take, drop_now;
  logic                  page_hit, is_reg, is_bank, word_ok, bank_ok, final_word, tag_hit;
  logic [4:0]            page5;
  logic [23:0]           reg_idx;
  logic [BANK_W-1:0]     dec_bank;
  logic [MEM_ADDR_W-1:0] dec_entry;
  logic [WSEL_W-1:0]     dec_word;
  logic [TAG_W-1:0]      dec_tag;
  logic [SH_W-1:0]       merged;
  logic [MEM_W-1:0]      rd_entry;
  logic [SH_W-1:0]       rd_pad;
  logic [31:0]           rd_word;

  // Address decode, shadow merge of the incoming word and read-word selection
  always_comb begin
    bus_req    = wbs_cyc_i & wbs_stb_i;
    take       = bus_req & ~wbs_ack_o & (state_q == IDLE);
    drop_now   = drop_q | ~bus_req;
    page_hit   = (wbs_adr_i[31:28] == 4'h3);
    page5      = {1'b0, wbs_adr_i[27:24]};
    reg_idx    = wbs_adr_i[23:0];
    is_reg     = page_hit && (page5 == 5'd0);
    is_bank    = page_hit && (page5 != 5'd0) && (page5 <= 5'(NUM_BANKS));
    dec_bank   = wbs_adr_i[27:24] - 4'd1;
    dec_entry  = wbs_adr_i[WSEL_W+MEM_ADDR_W-1:WSEL_W];
    dec_word   = wbs_adr_i[WSEL_W-1:0];
    word_ok    = 32'(dec_word) < WPE;
    final_word = 32'(dec_word) == (WPE - 1);
    bank_ok    = is_bank && word_ok && wbs_debug;
    dec_tag    = {dec_bank, dec_entry};
    tag_hit    = sh_valid_q && (sh_tag_q == dec_tag);
    merged     = tag_hit ? SH_W'(sh_data_q) : '0;
    for (int i = 0; i < 4; i++) begin
      if (wbs_sel_i[i]) merged[32'(dec_word)*32 + 32'(i)*8 +: 8] = wbs_dat_i[i*8 +: 8];
    end
    rd_entry   = mem_rdata[32'(req_bank_q)*MEM_W +: MEM_W];
    rd_pad     = SH_W'(rd_entry);
    rd_word    = rd_pad[32'(req_word_q)*32 +: 32];
  end

  // State register
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) state_q <= IDLE;
    else          state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (take) begin
          if (bank_ok && !wbs_we_i)     state_d = RD_REQ;
          else if (bank_ok && final_word) state_d = WR;
          else                          state_d = ACK;
        end
      end
      RD_REQ:  state_d = RD_WAIT;
      RD_WAIT: begin
        if (cnt_q == CNT_W'(READ_LATENCY - 1)) state_d = drop_now ? IDLE : ACK;
      end
      WR:      state_d = drop_now ? IDLE : ACK;
      ACK:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Output and datapath next values
  always_comb begin
    ack_d      = (state_d == ACK);
    dat_d      = '0;
    mode_d     = wbs_mode;
    debug_d    = wbs_debug;
    csb_d      = '1;
    web_d      = '1;
    addr_d     = mem_addr;
    wdata_d    = mem_wdata;
    sh_data_d  = sh_data_q;
    sh_tag_d   = sh_tag_q;
    sh_valid_d = sh_valid_q;
    req_bank_d = req_bank_q;
    req_word_d = req_word_q;
    cnt_d      = '0;
    drop_d     = 1'b0;

    if (state_q == RD_REQ || state_q == RD_WAIT || state_q == WR) drop_d = drop_now;
    if (state_q == RD_WAIT) cnt_d = cnt_q + CNT_W'(1);
    if (state_q == RD_WAIT && state_d == ACK) dat_d = rd_word;

    if (take) begin
      if (is_reg) begin
        if (wbs_we_i) begin
          if (reg_idx == 24'd0 && wbs_sel_i[0]) mode_d  = wbs_dat_i[0];
          if (reg_idx == 24'd1 && wbs_sel_i[0]) debug_d = wbs_dat_i[0];
        end else begin
          case (reg_idx)
            24'd0:   dat_d = {31'b0, wbs_mode};
            24'd1:   dat_d = {31'b0, wbs_debug};
            24'd2:   dat_d = {30'b0, sh_valid_q, wbs_debug};
            default: dat_d = '0;
          endcase
        end
      end else if (bank_ok) begin
        if (!wbs_we_i) begin
          req_bank_d = dec_bank;
          req_word_d = dec_word;
          addr_d     = dec_entry;
          for (int unsigned b = 0; b < NUM_BANKS; b++) begin
            if (BANK_W'(b) == dec_bank) csb_d[b] = 1'b0;
          end
        end else if (final_word) begin
          addr_d     = dec_entry;
          wdata_d    = merged[MEM_W-1:0];
          sh_data_d  = '0;
          sh_valid_d = 1'b0;
          for (int unsigned b = 0; b < NUM_BANKS; b++) begin
            if (BANK_W'(b) == dec_bank) begin
              csb_d[b] = 1'b0;
              web_d[b] = 1'b0;
            end
          end
        end else begin
          sh_data_d  = merged[MEM_W-1:0];
          sh_tag_d   = dec_tag;
          sh_valid_d = 1'b1;
        end
      end
    end
  end

  // Output and datapath registers
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      wbs_ack_o  <= 1'b0;
      wbs_dat_o  <= '0;
      wbs_mode   <= 1'b0;
      wbs_debug  <= 1'b0;
      mem_csb    <= '1;
      mem_web    <= '1;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      sh_data_q  <= '0;
      sh_tag_q   <= '0;
      sh_valid_q <= 1'b0;
      req_bank_q <= '0;
      req_word_q <= '0;
      cnt_q      <= '0;
      drop_q     <= 1'b0;
    end else begin
      wbs_ack_o  <= ack_d;
      wbs_dat_o  <= dat_d;
      wbs_mode   <= mode_d;
      wbs_debug  <= debug_d;
      mem_csb    <= csb_d;
      mem_web    <= web_d;
      mem_addr   <= addr_d;
      mem_wdata  <= wdata_d;
      sh_data_q  <= sh_data_d;
      sh_tag_q   <= sh_tag_d;
      sh_valid_q <= sh_valid_d;
      req_bank_q <= req_bank_d;
      req_word_q <= req_word_d;
      cnt_q      <= cnt_d;
      drop_q     <= drop_d;
    end
  end

endmodule

// File: tb/tb_wbs_multibank_ctrl.sv
// tb_wbs_multibank_ctrl: directed and random bus traffic checked against a word-level
// reference model of the registers, shadow entry and bank contents.
`timescale 1ns/1ps
module tb_wbs_multibank_ctrl;

  localparam int unsigned NUM_BANKS    = 4;
  localparam int unsigned MEM_W        = 64;
  localparam int unsigned MEM_ADDR_W   = 9;
  localparam int unsigned READ_LATENCY = 1;
  localparam int unsigned WPE          = 2;
  localparam int unsigned N_ENT        = 512;

  logic clk = 1'b0;
  logic rst;
  logic wb_cyc, wb_stb, wb_we;
  logic [3:0] wb_sel;
  logic [31:0] wb_dat_w, wb_adr;
  logic wb_ack;
  logic [31:0] wb_dat_r;
  logic mode_o, debug_o;
  logic [NUM_BANKS-1:0] mem_csb, mem_web;
  logic [MEM_ADDR_W-1:0] mem_addr;
  logic [MEM_W-1:0] mem_wdata;
  logic [NUM_BANKS*MEM_W-1:0] mem_rdata;

  int n_asrt = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  wbs_multibank_ctrl #(
    .NUM_BANKS(NUM_BANKS), .MEM_W(MEM_W), .MEM_ADDR_W(MEM_ADDR_W), .READ_LATENCY(READ_LATENCY)
  ) dut (
    .wb_clk_i(clk), .wb_rst_i(rst), .wbs_stb_i(wb_stb), .wbs_cyc_i(wb_cyc), .wbs_we_i(wb_we),
    .wbs_sel_i(wb_sel), .wbs_dat_i(wb_dat_w), .wbs_adr_i(wb_adr), .wbs_ack_o(wb_ack),
    .wbs_dat_o(wb_dat_r), .wbs_mode(mode_o), .wbs_debug(debug_o), .mem_csb(mem_csb),
    .mem_web(mem_web), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  // SRAM banks with one-cycle read latency plus a backdoor preload port
  logic [MEM_W-1:0] sram [NUM_BANKS][N_ENT];
  logic [MEM_W-1:0] rdata_q [NUM_BANKS];
  logic bd_en = 1'b0;
  logic [1:0] bd_b = '0;
  logic [8:0] bd_e = '0;
  logic [MEM_W-1:0] bd_v = '0;

  always @(posedge clk) begin
    if (bd_en) sram[bd_b][bd_e] <= bd_v;
    for (int b = 0; b < NUM_BANKS; b++) begin
      if (!mem_csb[b]) begin
        if (!mem_web[b]) sram[b][mem_addr] <= mem_wdata;
        else             rdata_q[b] <= sram[b][mem_addr];
      end
    end
  end

  always_comb begin
    mem_rdata = '0;
    for (int b = 0; b < NUM_BANKS; b++) mem_rdata[b*MEM_W +: MEM_W] = rdata_q[b];
  end

  // Reference model state
  logic m_mode, m_debug, m_sh_valid;
  int m_sh_bank, m_sh_entry;
  logic [31:0] m_sh_word [WPE];
  logic [MEM_W-1:0] ref_mem [NUM_BANKS][8];

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_asrt++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic backdoor(input int b, input int e, input logic [MEM_W-1:0] v);
    @(negedge clk);
    bd_en = 1'b1; bd_b = 2'(b); bd_e = 9'(e); bd_v = v;
    @(negedge clk);
    bd_en = 1'b0;
    ref_mem[b][e] = v;
  endtask

  task automatic model_reset();
    m_mode = 1'b0; m_debug = 1'b0; m_sh_valid = 1'b0; m_sh_bank = 0; m_sh_entry = 0;
    for (int i = 0; i < WPE; i++) m_sh_word[i] = '0;
  endtask

  // One bus transfer; records ack latency, read data and any SRAM strobe seen
  task automatic xfer(input logic we, input logic [31:0] adr, input logic [3:0] sel,
                      input logic [31:0] dat, output int lat, output logic [31:0] rdat,
                      output int nstb, output int nlow, output int sbank, output logic sweb,
                      output logic [8:0] saddr, output logic [63:0] swd);
    lat = 0; rdat = '0; nstb = 0; nlow = 0; sbank = -1; sweb = 1'b1; saddr = '0; swd = '0;
    @(negedge clk);
    wb_cyc = 1'b1; wb_stb = 1'b1; wb_we = we; wb_adr = adr; wb_sel = sel; wb_dat_w = dat;
    for (int k = 1; k <= 12; k++) begin
      @(negedge clk);
      if (mem_csb != '1) begin
        nstb++;
        for (int b = 0; b < NUM_BANKS; b++) begin
          if (!mem_csb[b]) begin nlow++; sbank = b; sweb = mem_web[b]; end
        end
        saddr = mem_addr; swd = mem_wdata;
      end
      if (wb_ack) begin lat = k; rdat = wb_dat_r; break; end
    end
    wb_cyc = 1'b0; wb_stb = 1'b0; wb_we = 1'b0;
  endtask

  // Predict a transfer from the address map, run it, compare, then advance the model
  task automatic op(input string tag, input logic we, input logic [31:0] adr,
                    input logic [3:0] sel, input logic [31:0] dat,
                    output logic [31:0] o_dat, output logic [63:0] o_wd);
    int e_lat, e_stb, e_bank, pg, bk, ent, wd, idx;
    logic [31:0] e_dat;
    logic e_web, hit, is_bank;
    logic [63:0] e_wd;
    logic [31:0] words [WPE];
    int lat, nstb, nlow, sbank;
    logic [31:0] rdat;
    logic sweb;
    logic [8:0] saddr;
    logic [63:0] swd;
    e_lat = 1; e_stb = 0; e_bank = 0; e_dat = '0; e_web = 1'b1; e_wd = '0;
    pg = int'(adr[27:24]); bk = pg - 1; ent = int'(adr[9:1]); wd = int'(adr[0]);
    idx = int'(adr[23:0]);
    is_bank = (adr[31:28] == 4'h3) && pg >= 1 && pg <= NUM_BANKS && m_debug;
    hit = m_sh_valid && m_sh_bank == bk && m_sh_entry == ent;
    for (int i = 0; i < WPE; i++) words[i] = hit ? m_sh_word[i] : 32'h0;
    for (int i = 0; i < 4; i++) if (sel[i]) words[wd][i*8 +: 8] = dat[i*8 +: 8];
    if (adr[31:28] == 4'h3 && pg == 0 && !we) begin
      if (idx == 0) e_dat = {31'b0, m_mode};
      else if (idx == 1) e_dat = {31'b0, m_debug};
      else if (idx == 2) e_dat = {30'b0, m_sh_valid, m_debug};
    end else if (is_bank && !we) begin
      e_lat = 2 + READ_LATENCY; e_stb = 1; e_bank = bk;
      e_dat = ref_mem[bk][ent][wd*32 +: 32];
    end else if (is_bank && wd == WPE - 1) begin
      e_lat = 2; e_stb = 1; e_bank = bk; e_web = 1'b0;
      e_wd = {words[1], words[0]};
    end

    xfer(we, adr, sel, dat, lat, rdat, nstb, nlow, sbank, sweb, saddr, swd);
    o_dat = rdat; o_wd = swd;

    check({tag, "_lat"}, 64'(lat), 64'(e_lat));
    if (!we) check({tag, "_dat"}, 64'(rdat), 64'(e_dat));
    check({tag, "_nstb"}, 64'(nstb), 64'(e_stb));
    if (e_stb == 1 && nstb == 1) begin
      check({tag, "_nlow"}, 64'(nlow), 64'd1);
      check({tag, "_bank"}, 64'(sbank), 64'(e_bank));
      check({tag, "_web"}, 64'(sweb), 64'(e_web));
      check({tag, "_addr"}, 64'(saddr), 64'(ent));
      if (!e_web) check({tag, "_wdata"}, swd, e_wd);
    end

    if (adr[31:28] == 4'h3 && pg == 0 && we && sel[0]) begin
      if (idx == 0) m_mode = dat[0];
      if (idx == 1) m_debug = dat[0];
    end else if (is_bank && we) begin
      if (wd == WPE - 1) begin
        ref_mem[bk][ent] = e_wd;
        m_sh_valid = 1'b0;
        for (int i = 0; i < WPE; i++) m_sh_word[i] = '0;
      end else begin
        for (int i = 0; i < WPE; i++) m_sh_word[i] = words[i];
        m_sh_bank = bk; m_sh_entry = ent; m_sh_valid = 1'b1;
      end
    end
    check({tag, "_mode_out"}, 64'(mode_o), 64'(m_mode));
    check({tag, "_debug_out"}, 64'(debug_o), 64'(m_debug));
  endtask

  initial begin : main
    logic [31:0] od, adr, dat;
    logic [63:0] ow;
    logic [3:0] sel, pat;
    logic we;
    int acks, r, b, e, w;

    rst = 1'b1; wb_cyc = 1'b0; wb_stb = 1'b0; wb_we = 1'b0;
    wb_sel = '0; wb_dat_w = '0; wb_adr = '0;
    model_reset();
    repeat (3) @(negedge clk);
    check("rst_ack", 64'(wb_ack), 64'd0);
    check("rst_dat", 64'(wb_dat_r), 64'd0);
    check("rst_mode", 64'(mode_o), 64'd0);
    check("rst_debug", 64'(debug_o), 64'd0);
    check("rst_csb", 64'(mem_csb), 64'hF);
    check("rst_web", 64'(mem_web), 64'hF);
    check("rst_addr", 64'(mem_addr), 64'd0);
    check("rst_wdata", mem_wdata, 64'd0);
    rst = 1'b0;

    for (int bb = 0; bb < NUM_BANKS; bb++)
      for (int ee = 0; ee < 8; ee++) backdoor(bb, ee, {$urandom, $urandom});

    // Register page: debug, mode, status
    op("t1_wdbg", 1'b1, 32'h3000_0001, 4'hF, 32'h1, od, ow);
    op("t1_wmode", 1'b1, 32'h3000_0000, 4'hF, 32'h1, od, ow);
    op("t1_status", 1'b0, 32'h3000_0002, 4'hF, 32'h0, od, ow);
    check("t1_status_const", 64'(od), 64'h1);

    // Bank read of a known entry
    backdoor(0, 1, 64'h0000_1010_DEAD_BEEF);
    op("t2_rd_w0", 1'b0, 32'h3100_0002, 4'hF, 32'h0, od, ow);
    check("t2_w0_const", 64'(od), 64'hDEAD_BEEF);
    op("t2_rd_w1", 1'b0, 32'h3100_0003, 4'hF, 32'h0, od, ow);
    check("t2_w1_const", 64'(od), 64'h0000_1010);

    // Two-word write commits once
    op("t3_w0", 1'b1, 32'h3200_0004, 4'hF, 32'h0123_4567, od, ow);
    op("t3_status", 1'b0, 32'h3000_0002, 4'hF, 32'h0, od, ow);
    op("t3_w1", 1'b1, 32'h3200_0005, 4'hF, 32'h000B_CDEF, od, ow);
    check("t3_wdata_const", ow, 64'h000B_CDEF_0123_4567);
    op("t3_rdback", 1'b0, 32'h3200_0004, 4'hF, 32'h0, od, ow);

    // Byte enables on the shadow
    op("t4_w0", 1'b1, 32'h3200_0006, 4'b0011, 32'hFFFF_AAAA, od, ow);
    op("t4_w1", 1'b1, 32'h3200_0007, 4'hF, 32'h0, od, ow);
    check("t4_wdata_const", ow, 64'h0000_0000_0000_AAAA);

    // Debug gating and unmapped page
    op("t5_dbg0", 1'b1, 32'h3000_0001, 4'hF, 32'h0, od, ow);
    op("t5_rd", 1'b0, 32'h3300_0000, 4'hF, 32'h0, od, ow);
    op("t5_wr", 1'b1, 32'h3300_0001, 4'hF, 32'h1234_5678, od, ow);
    op("t5_unmap", 1'b0, 32'h3F00_0000, 4'hF, 32'h0, od, ow);
    op("t5_dbg1", 1'b1, 32'h3000_0001, 4'hF, 32'h1, od, ow);

    // Reset during RD_WAIT with the request still held
    op("t6_mode", 1'b1, 32'h3000_0000, 4'hF, 32'h1, od, ow);
    @(negedge clk);
    wb_cyc = 1'b1; wb_stb = 1'b1; wb_we = 1'b0; wb_adr = 32'h3100_0002; wb_sel = 4'hF;
    @(negedge clk);
    check("t6_csb_req", 64'(mem_csb), 64'hE);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("t6_ack", 64'(wb_ack), 64'd0);
    check("t6_csb", 64'(mem_csb), 64'hF);
    check("t6_mode", 64'(mode_o), 64'd0);
    check("t6_debug", 64'(debug_o), 64'd0);
    rst = 1'b0; wb_cyc = 1'b0; wb_stb = 1'b0;
    model_reset();
    op("t6_after_dbg", 1'b1, 32'h3000_0001, 4'hF, 32'h1, od, ow);
    op("t6_after_rd", 1'b0, 32'h3100_0003, 4'hF, 32'h0, od, ow);

    // Request held across ack is taken again one cycle later
    pat = 4'b0101;
    @(negedge clk);
    wb_cyc = 1'b1; wb_stb = 1'b1; wb_we = 1'b0; wb_adr = 32'h3000_0001; wb_sel = 4'hF;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      check("b2b_ack", 64'(wb_ack), 64'(pat[k]));
      if (pat[k]) check("b2b_dat", 64'(wb_dat_r), 64'(m_debug));
    end
    wb_cyc = 1'b0; wb_stb = 1'b0;

    // Strobe dropped during a bank read: no ack
    @(negedge clk);
    wb_cyc = 1'b1; wb_stb = 1'b1; wb_we = 1'b0; wb_adr = 32'h3100_0002;
    @(negedge clk);
    wb_cyc = 1'b0; wb_stb = 1'b0;
    acks = 0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      if (wb_ack) acks++;
    end
    check("drop_noack", 64'(acks), 64'd0);
    op("drop_after", 1'b0, 32'h3100_0002, 4'hF, 32'h0, od, ow);

    // Random traffic
    for (int n = 0; n < 300; n++) begin
      r = int'($urandom_range(0, 9));
      we = 1'($urandom_range(0, 1));
      sel = 4'($urandom);
      dat = $urandom;
      if (r == 0) begin
        adr = {8'h30, 24'($urandom_range(0, 3))};
        if (we && adr[1:0] == 2'd1) begin
          sel[0] = 1'b1;
          dat[0] = ($urandom_range(0, 3) != 0);
        end
      end else if (r == 1) begin
        adr = {4'($urandom), 4'($urandom), 24'($urandom_range(0, 7))};
      end else begin
        b = int'($urandom_range(0, NUM_BANKS));
        e = int'($urandom_range(0, 3));
        w = int'($urandom_range(0, 1));
        adr = 32'h3000_0000 | (32'(b + 1) << 24) | (32'(e) << 1) | 32'(w);
      end
      op("rnd", we, adr, sel, dat, od, ow);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_asrt, n_fail);
    $finish;
  end

endmodule
